// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared glyphs, LFSR constants and BCD helper for the game
//                datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [0:0] {
        PAGE_PLAY   = 1'b0,
        PAGE_RESULT = 1'b1
    } page_e;

    // Active-high segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_GLYPH_L     = 7'h38;
    localparam logic [6:0] c_GLYPH_T     = 7'h78;
    localparam logic [6:0] c_GLYPH_R     = 7'h50;
    localparam logic [6:0] c_GLYPH_U     = 7'h3E;
    localparam logic [6:0] c_GLYPH_S     = 7'h6D;
    localparam logic [6:0] c_GLYPH_E     = 7'h79;
    localparam logic [6:0] c_GLYPH_F     = 7'h71;
    localparam logic [6:0] c_GLYPH_P     = 7'h73;
    localparam logic [6:0] c_GLYPH_G     = 7'h6F;
    localparam logic [6:0] c_GLYPH_A     = 7'h77;
    localparam logic [6:0] c_GLYPH_BLANK = 7'h00;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  c_BCD_MAX   = 8'h99;

    function automatic logic [7:0] bcd_add_sat(input logic [7:0] val, input logic [2:0] inc);
        logic [4:0] units;
        logic [4:0] tens;
        units = {1'b0, val[3:0]} + {2'b00, inc};
        tens  = {1'b0, val[7:4]};
        if (units > 5'd9) begin
            units = units - 5'd10;
            tens  = tens + 5'd1;
        end
        if (tens > 5'd9) begin
            return c_BCD_MAX;
        end
        return {tens[3:0], units[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec7seg.sv
`default_nettype none
// ============================================================================
//  Module      : dec7seg
//  Description : Hex digit to active-high seven-segment pattern {g..a}.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec7seg (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h00;
        case (i_digit)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            default: o_seg = 7'h71;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/game_datapath_v2_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle tick every
//                CLK_DIV clocks; restartable by reset or clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/game_datapath_v2.sv
`default_nettype none
// ============================================================================
//  Module      : game_datapath_v2
//  Description : Memory-game datapath: timer, LFSR sequence playback, guess
//                scoring and seven-segment pages. Option macro: GAME_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_datapath_v2 #(
    parameter int N_SW       = 8,
    parameter int N_ROUNDS   = 9,
    parameter int TIME_LIMIT = 10,
    parameter int CLK_DIV    = 50_000_000
) (
    input  logic            CLOCK_50,
    input  logic            R1,
    input  logic            R2,
    input  logic            E1,
    input  logic            E2,
    input  logic            E3,
    input  logic            E4,
    input  logic            SEL,
    input  logic [3:0]      KEY,
    input  logic [N_SW-1:0] SWITCH,
    output logic [6:0]      hex0,
    output logic [6:0]      hex1,
    output logic [6:0]      hex2,
    output logic [6:0]      hex3,
    output logic [6:0]      hex4,
    output logic [6:0]      hex5,
    output logic [3:0]      leds,
    output logic            end_FPGA,
    output logic            end_User,
    output logic            end_time,
    output logic            win,
    output logic            match
);
    import game_pkg::*;

    localparam logic [3:0] c_TIME_LIMIT = 4'(TIME_LIMIT);
    localparam logic [3:0] c_ROUNDS     = 4'(N_ROUNDS);
    localparam logic [2:0] c_LAST_IDX   = 3'(N_SW / 4 - 1);

    logic            w_tick;
    logic [3:0]      r_timer;
    logic [15:0]     r_lfsr;
    logic [N_SW-1:0] r_seq;
    logic [N_SW-1:0] r_guess;
    logic [N_SW-1:0] w_seq_shift;
    logic [2:0]      r_idx;
    logic            r_active;
    logic            r_end_fpga;
    logic            r_end_user;
    logic [7:0]      r_points;
    logic [3:0]      r_round;
    logic [3:0]      w_round_nxt;
    logic            r_win;
    logic [1:0]      r_level;
    logic            w_match;
    logic            w_blank;
    logic            w_unused_key;

    assign w_unused_key = ^KEY[3:2];

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk     (CLOCK_50),
        .rst     (R1),
        .i_clear (R2),
        .o_tick  (w_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (R1 || R2) begin
            r_timer <= c_TIME_LIMIT;
        end else if (E2 && w_tick && (r_timer != 4'd0)) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (R1) begin
            r_lfsr  <= c_LFSR_SEED;
            r_level <= ~KEY[1:0];
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & c_LFSR_TAPS)};
        end
    end

    // Playback walks the sequence one nibble per tick, LSB nibble first
    always_ff @(posedge CLOCK_50) begin
        if (R1) begin
            r_seq      <= '0;
            r_idx      <= 3'd0;
            r_active   <= 1'b0;
            r_end_fpga <= 1'b0;
        end else if (E1) begin
            r_seq      <= r_lfsr[N_SW-1:0];
            r_idx      <= 3'd0;
            r_active   <= 1'b1;
            r_end_fpga <= 1'b0;
        end else if (r_active && w_tick) begin
            if (r_idx == c_LAST_IDX) begin
                r_idx      <= 3'd0;
                r_active   <= 1'b0;
                r_end_fpga <= 1'b1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign w_seq_shift = r_seq >> {r_idx, 2'b00};
    assign leds        = r_active ? w_seq_shift[3:0] : 4'h0;

    always_ff @(posedge CLOCK_50) begin
        if (R1) begin
            r_guess    <= '0;
            r_end_user <= 1'b0;
        end else begin
            if (E3) begin
                r_guess <= SWITCH;
            end
            if (E1) begin
                r_end_user <= 1'b0;
            end else if (E3) begin
                r_end_user <= 1'b1;
            end
        end
    end

    assign w_match     = (r_guess == r_seq);
    assign w_round_nxt = (r_round == c_ROUNDS) ? r_round : r_round + 1'b1;

    // Scoring sees the registered guess, so a same-cycle E3 does not count yet
    always_ff @(posedge CLOCK_50) begin
        if (R1) begin
            r_points <= 8'h00;
            r_round  <= 4'd0;
            r_win    <= 1'b0;
        end else if (E4) begin
            if (w_match) begin
                r_points <= bcd_add_sat(r_points, {1'b0, r_level} + 3'd1);
            end
            r_round <= w_round_nxt;
            r_win   <= (w_round_nxt == c_ROUNDS) && w_match;
        end
    end

`ifdef GAME_BLINK_EN
    logic r_blink;

    always_ff @(posedge CLOCK_50) begin
        if (R1) begin
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_blank = r_blink;
`else
    assign w_blank = 1'b0;
`endif

    logic [3:0] w_digit [5];
    logic [6:0] w_seg   [5];

    assign w_digit[0] = {2'b00, r_level};
    assign w_digit[1] = r_timer;
    assign w_digit[2] = r_round;
    assign w_digit[3] = r_points[7:4];
    assign w_digit[4] = r_points[3:0];

    for (genvar gi = 0; gi < 5; gi++) begin : g_dec
        dec7seg u_dec (
            .i_digit (w_digit[gi]),
            .o_seg   (w_seg[gi])
        );
    end

    always_comb begin
        hex5 = c_GLYPH_L;
        hex4 = w_seg[0];
        hex3 = c_GLYPH_T;
        hex2 = w_seg[1];
        hex1 = c_GLYPH_R;
        hex0 = w_seg[2];
        if (page_e'(SEL) == PAGE_RESULT) begin
            if (w_blank) begin
                hex5 = c_GLYPH_BLANK;
                hex4 = c_GLYPH_BLANK;
                hex3 = c_GLYPH_BLANK;
                hex2 = c_GLYPH_BLANK;
            end else if (r_win) begin
                hex5 = c_GLYPH_U;
                hex4 = c_GLYPH_S;
                hex3 = c_GLYPH_E;
                hex2 = c_GLYPH_R;
            end else begin
                hex5 = c_GLYPH_F;
                hex4 = c_GLYPH_P;
                hex3 = c_GLYPH_G;
                hex2 = c_GLYPH_A;
            end
            hex1 = w_seg[3];
            hex0 = w_seg[4];
        end
    end

    assign end_FPGA = r_end_fpga;
    assign end_User = r_end_user;
    assign end_time = (r_timer == 4'd0);
    assign win      = r_win;
    assign match    = w_match;
endmodule
`default_nettype wire

// File: doc/game_datapath_v2.md
GAME_DATAPATH_V2 -- requirements
Module: game_datapath_v2

Interface
REQ-001 Parameter N_SW, default 8, switch/sequence width; SHALL be a multiple of 4, range 4..16.
REQ-002 Parameter N_ROUNDS, default 9, last round index (1..9).
REQ-003 Parameter TIME_LIMIT, default 10, countdown start value in ticks (1..15).
REQ-004 Parameter CLK_DIV, default 50_000_000, CLOCK_50 cycles per tick (>=2).
REQ-005 CLOCK_50  in  1  sole clock, all state rising-edge.
REQ-006 R1  in  1  synchronous active-high reset of the whole block.
REQ-007 R2, E1, E2, E3, E4  in  1 each  control commands: timer reload, sequence load, timer enable, user latch, round commit.
REQ-008 SEL  in  1  display page select: 0 = play page, 1 = result page.
REQ-009 KEY  in  4  active-low keys; KEY[1:0] SHALL be latched as level on R1.
REQ-010 SWITCH  in  N_SW  user guess.
REQ-011 hex0..hex5  out  7 each  seven-segment patterns, active-high, dec7seg encoding.
REQ-012 leds  out  4  sequence playback nibble.
REQ-013 end_FPGA, end_User, end_time, win, match  out  1 each  status flags to control unit.

Function
REQ-014 Tick: one-cycle pulse every CLK_DIV cycles, free-running; prescaler cleared by R1 and by R2.
REQ-015 Timer: R2 loads TIME_LIMIT; while E2 and timer>0, decrement on tick; end_time = (timer==0); hold at 0; R2 wins over simultaneous decrement.
REQ-016 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on R1, advances every cycle; never reaches zero.
REQ-017 E1: seq <= LFSR[N_SW-1:0], playback index <= 0, end_FPGA <= 0.
REQ-018 Playback: leds = seq nibble at index; index increments on tick; after last nibble (N_SW/4 ticks) leds <= 0 and end_FPGA <= 1, held until next E1.
REQ-019 E3: guess <= SWITCH, end_User <= 1; cleared by E1; match = (guess == seq) combinational from registers.
REQ-020 E4: if match, points += level+1 in 2-digit BCD, saturate at 99; round increments, saturating at N_ROUNDS; E4 with E3 same cycle SHALL use the previously latched guess.
REQ-021 win = (round == N_ROUNDS) && match, registered on E4.
REQ-022 Page SEL=0: hex5 "L", hex4 level digit, hex3 "t", hex2 timer digit, hex1 "r", hex0 round digit.
REQ-023 Page SEL=1: hex5..hex2 spell "USEr" if win else "FPgA"; hex1/hex0 points tens/units.
REQ-024 Display outputs combinational from registers; no added latency beyond register update.

Reset
REQ-025 On R1: timer=TIME_LIMIT, seq=0, guess=0, points=00, round=0, index=0, leds=0, level=~KEY[1:0].
REQ-026 Post-reset flags: end_FPGA=0, end_User=0, win=0, end_time=0, match=1 (0==0).
REQ-027 R1 mid-playback or mid-countdown SHALL abort immediately; no pulse or flag survives.

Configuration
REQ-028 Macro GAME_BLINK_EN: when defined, on SEL=1 hex5..hex2 blank on alternate ticks (phase toggled per tick, cleared by R1); hex1/hex0 steady.
REQ-029 Without GAME_BLINK_EN: no blink register; result page steady.

Structure
REQ-030 Package game_pkg: glyph constants (L,t,r,U,S,E,F,P,g,A, blank), LFSR seed/taps, BCD max 99.
REQ-031 Sub-module tick_prescaler (CLK_DIV parameter, clear input, tick output); existing dec7seg reused for digits.

Verification (CLK_DIV=4, N_SW=8, TIME_LIMIT=3)
REQ-032 R1, then idle 20 cycles -> all flags 0 except match=1; timer=3; hex2 shows "3".
REQ-033 R2, E2 held -> timer 3,2,1,0 at 4-cycle ticks; end_time=1 after 12 cycles; stays 0 for 8 more.
REQ-034 E1 with LFSR slice 8'hE1 -> leds 1 then E on successive ticks, then 0; end_FPGA=1 after 2 ticks.
REQ-035 KEY=4'b1101 at R1 (level 2); SWITCH=seq, E3, E4 -> match=1, points 03; repeat to 99 -> holds 99.
REQ-036 Nine correct E4 with N_ROUNDS=9 -> win=1; SEL=1 shows "USEr"; with GAME_BLINK_EN hex5..hex2 blank on alternate ticks.
REQ-037 R1 asserted mid-playback -> next cycle leds=0, end_FPGA=0, index=0.
